// File: rtl/riscv_pkg.sv
// rtl/riscv_pkg.sv - shared IF/ID payload types and bubble constants
package riscv_pkg;

  localparam int XLEN = 32;
  localparam logic [XLEN-1:0] NOP_INSTR_DFLT = 32'h00000013;

  typedef struct packed {
    logic [XLEN-1:0] instr;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] pc_plus_4;
    logic [XLEN-1:0] imm_ext;
  } if_id_t;

  // Payload presented to decode when the stage holds no valid entry.
  function automatic if_id_t if_id_bubble(input logic [XLEN-1:0] nop);
    if_id_t b;
    b           = '0;
    b.instr     = nop;
    return b;
  endfunction

endpackage

// File: rtl/pipe_skid_buf.sv
// rtl/pipe_skid_buf.sv - generic valid/ready pipeline register with optional skid entry and flush
module pipe_skid_buf #(
  parameter int W       = 8,
  parameter bit SKID_EN = 1'b1
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         flush_i,
  input  logic         valid_i,
  output logic         ready_o,
  input  logic [W-1:0] data_i,
  output logic         valid_o,
  input  logic         ready_i,
  output logic [W-1:0] data_o
);

  generate
    if (SKID_EN) begin : g_skid
      logic         main_valid_q, main_valid_d;
      logic         skid_valid_q, skid_valid_d;
      logic [W-1:0] main_data_q, main_data_d;
      logic [W-1:0] skid_data_q, skid_data_d;
      logic         accept, consume;

      always_comb begin
        accept       = valid_i & ~skid_valid_q;
        consume      = main_valid_q & ready_i;
        main_valid_d = main_valid_q;
        skid_valid_d = skid_valid_q;
        main_data_d  = main_data_q;
        skid_data_d  = skid_data_q;
        if (flush_i) begin
          main_valid_d = 1'b0;
          skid_valid_d = 1'b0;
        end else if (!main_valid_q || consume) begin
          // ready_o is low while skid is full, so accept cannot coincide with a skid drain.
          if (skid_valid_q) begin
            main_valid_d = 1'b1;
            main_data_d  = skid_data_q;
            skid_valid_d = 1'b0;
          end else begin
            main_valid_d = accept;
            if (accept) main_data_d = data_i;
          end
        end else if (accept) begin
          skid_valid_d = 1'b1;
          skid_data_d  = data_i;
        end
      end

      always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
          main_valid_q <= 1'b0;
          skid_valid_q <= 1'b0;
          main_data_q  <= '0;
          skid_data_q  <= '0;
        end else begin
          main_valid_q <= main_valid_d;
          skid_valid_q <= skid_valid_d;
          main_data_q  <= main_data_d;
          skid_data_q  <= skid_data_d;
        end
      end

      assign ready_o = ~skid_valid_q;
      assign valid_o = main_valid_q;
      assign data_o  = main_data_q;
    end else begin : g_noskid
      logic         main_valid_q, main_valid_d;
      logic [W-1:0] main_data_q, main_data_d;
      logic         accept;

      always_comb begin
        accept       = valid_i & (ready_i | ~main_valid_q);
        main_valid_d = main_valid_q;
        main_data_d  = main_data_q;
        if (flush_i) begin
          main_valid_d = 1'b0;
        end else if (accept) begin
          main_valid_d = 1'b1;
          main_data_d  = data_i;
        end else if (ready_i) begin
          main_valid_d = 1'b0;
        end
      end

      always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
          main_valid_q <= 1'b0;
          main_data_q  <= '0;
        end else begin
          main_valid_q <= main_valid_d;
          main_data_q  <= main_data_d;
        end
      end

      assign ready_o = ready_i | ~main_valid_q;
      assign valid_o = main_valid_q;
      assign data_o  = main_data_q;
    end
  endgenerate

endmodule

// File: rtl/if_id_skid_reg.sv
// rtl/if_id_skid_reg.sv - fetch->decode pipeline register with skid, flush and NOP bubbles
module if_id_skid_reg
  import riscv_pkg::*;
#(
  parameter int          DW        = 32,
  parameter bit          SKID_EN   = 1'b1,
  parameter logic [31:0] NOP_INSTR = NOP_INSTR_DFLT
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          flush_i,
  input  logic          valid_f,
  output logic          ready_f,
  input  logic [DW-1:0] instr_f,
  input  logic [DW-1:0] pc_f,
  input  logic [DW-1:0] pc_plus_4_f,
  input  logic [DW-1:0] imm_ext_f,
  output logic          valid_d,
  input  logic          ready_d,
  output logic [DW-1:0] instr_d,
  output logic [DW-1:0] pc_d,
  output logic [DW-1:0] pc_plus_4_d,
  output logic [DW-1:0] imm_ext_d
);

  if_id_t pl_f, pl_q, pl_d;

  always_comb begin
    pl_f.instr     = instr_f;
    pl_f.pc        = pc_f;
    pl_f.pc_plus_4 = pc_plus_4_f;
    pl_f.imm_ext   = imm_ext_f;
  end

  pipe_skid_buf #(
    .W       ($bits(if_id_t)),
    .SKID_EN (SKID_EN)
  ) u_buf (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .flush_i (flush_i),
    .valid_i (valid_f),
    .ready_o (ready_f),
    .data_i  (pl_f),
    .valid_o (valid_d),
    .ready_i (ready_d),
    .data_o  (pl_q)
  );

  // Decode sees a clean NOP bubble whenever nothing valid is held.
  assign pl_d        = valid_d ? pl_q : if_id_bubble(NOP_INSTR);
  assign instr_d     = pl_d.instr;
  assign pc_d        = pl_d.pc;
  assign pc_plus_4_d = pl_d.pc_plus_4;
  assign imm_ext_d   = pl_d.imm_ext;

endmodule

// File: tb/tb_if_id_skid_reg.sv
// tb/tb_if_id_skid_reg.sv - randomized and directed bench for if_id_skid_reg against a FIFO reference model
module tb_if_id_skid_reg;

  localparam logic [31:0]  NOP = 32'h00000013;
  localparam logic [127:0] BUBBLE = {NOP, 96'b0};

  logic clk = 1'b0;
  logic rst_i = 1'b1;
  always #5 clk = ~clk;

  logic         flush1 = 0, vf1 = 0, rdy1 = 0, ready_f1, valid_d1;
  logic         flush0 = 0, vf0 = 0, rdy0 = 0, ready_f0, valid_d0;
  logic [127:0] in1 = '0, in0 = '0;
  logic [31:0]  i_d1, p_d1, p4_d1, m_d1, i_d0, p_d0, p4_d0, m_d0;
  logic [127:0] out1, out0;
  assign out1 = {i_d1, p_d1, p4_d1, m_d1};
  assign out0 = {i_d0, p_d0, p4_d0, m_d0};

  int total = 0;
  int bad   = 0;
  logic [127:0] q1[$];
  logic [127:0] q0[$];

  if_id_skid_reg #(.DW(32), .SKID_EN(1'b1), .NOP_INSTR(NOP)) u_dut (
    .clk_i(clk), .rst_i(rst_i), .flush_i(flush1),
    .valid_f(vf1), .ready_f(ready_f1),
    .instr_f(in1[127:96]), .pc_f(in1[95:64]), .pc_plus_4_f(in1[63:32]), .imm_ext_f(in1[31:0]),
    .valid_d(valid_d1), .ready_d(rdy1),
    .instr_d(i_d1), .pc_d(p_d1), .pc_plus_4_d(p4_d1), .imm_ext_d(m_d1)
  );

  if_id_skid_reg #(.DW(32), .SKID_EN(1'b0), .NOP_INSTR(NOP)) u_dut0 (
    .clk_i(clk), .rst_i(rst_i), .flush_i(flush0),
    .valid_f(vf0), .ready_f(ready_f0),
    .instr_f(in0[127:96]), .pc_f(in0[95:64]), .pc_plus_4_f(in0[63:32]), .imm_ext_f(in0[31:0]),
    .valid_d(valid_d0), .ready_d(rdy0),
    .instr_d(i_d0), .pc_d(p_d0), .pc_plus_4_d(p4_d0), .imm_ext_d(m_d0)
  );

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [127:0] mk(input logic [31:0] pc);
    return {$urandom(), pc, pc + 32'd4, $urandom()};
  endfunction

  // Model: the stage is a FIFO of depth 2 (skid) or 1 (no skid); flush empties it.
  task automatic cycle();
    bit can1, can0, pop1, pop0;
    @(negedge clk);
    chk("s1_valid", 128'(valid_d1), 128'(q1.size() > 0));
    chk("s1_ready", 128'(ready_f1), 128'(q1.size() < 2));
    chk("s1_pay", out1, (q1.size() > 0) ? q1[0] : BUBBLE);
    chk("s0_valid", 128'(valid_d0), 128'(q0.size() > 0));
    chk("s0_ready", 128'(ready_f0), 128'(rdy0 || q0.size() == 0));
    chk("s0_pay", out0, (q0.size() > 0) ? q0[0] : BUBBLE);
    can1 = q1.size() < 2;
    pop1 = (q1.size() > 0) && rdy1;
    can0 = rdy0 || (q0.size() == 0);
    pop0 = (q0.size() > 0) && rdy0;
    if (flush1) q1.delete();
    else begin
      if (pop1) void'(q1.pop_front());
      if (vf1 && can1) q1.push_back(in1);
    end
    if (flush0) q0.delete();
    else begin
      if (pop0) void'(q0.pop_front());
      if (vf0 && can0) q0.push_back(in0);
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1;
    chk("rst_valid", 128'(valid_d1), 128'(0));
    chk("rst_pay", out1, BUBBLE);
    chk("rst_ready", 128'(ready_f1), 128'(1));
    rst_i = 1'b0;

    // Stream pc 0..0x10 at full rate
    rdy1 = 1; rdy0 = 1;
    for (int i = 0; i < 5; i++) begin
      vf1 = 1; in1 = mk(32'(4 * i));
      cycle();
      chk("t2_pc", 128'(p_d1), 128'(4 * i));
      chk("t2_valid", 128'(valid_d1), 128'(1));
    end

    // Back-pressure: 0x10 held, 0x14 goes to skid
    rdy1 = 0; vf1 = 1; in1 = mk(32'h14);
    cycle();
    chk("t3_hold", 128'(p_d1), 128'(32'h10));
    chk("t3_rdyf", 128'(ready_f1), 128'(0));
    rdy1 = 1; vf1 = 0;
    cycle();
    chk("t3_next", 128'(p_d1), 128'(32'h14));
    cycle();
    chk("t3_empty", 128'(valid_d1), 128'(0));

    // Flush while main and skid are full
    rdy1 = 0; vf1 = 1; in1 = mk(32'h20);
    cycle();
    in1 = mk(32'h24);
    cycle();
    chk("t4_full", 128'(ready_f1), 128'(0));
    flush1 = 1; vf1 = 0;
    cycle();
    flush1 = 0;
    chk("t4_valid", 128'(valid_d1), 128'(0));
    chk("t4_instr", 128'(i_d1), 128'(NOP));
    chk("t4_rdyf", 128'(ready_f1), 128'(1));
    rdy1 = 1;
    cycle();
    cycle();
    chk("t4_gone", 128'(valid_d1), 128'(0));

    // Flush drops same-cycle input
    flush1 = 1; vf1 = 1; in1 = mk(32'h40);
    cycle();
    flush1 = 0; in1 = mk(32'h44);
    cycle();
    chk("t5_pc", 128'(p_d1), 128'(32'h44));
    chk("t5_valid", 128'(valid_d1), 128'(1));
    vf1 = 0;
    cycle();

    // No-skid variant: combinational ready_f
    rdy0 = 0; vf0 = 1; in0 = mk(32'h80);
    cycle();
    vf0 = 0;
    #1 chk("t6_rdy_lo", 128'(ready_f0), 128'(0));
    rdy0 = 1;
    #1 chk("t6_rdy_hi", 128'(ready_f0), 128'(1));
    cycle();

    // Random traffic on both variants, with an asynchronous reset mid-stream
    for (int n = 0; n < 600; n++) begin
      vf1 = $urandom_range(0, 3) != 0; rdy1 = $urandom_range(0, 2) != 0;
      flush1 = $urandom_range(0, 15) == 0; in1 = mk($urandom());
      vf0 = $urandom_range(0, 3) != 0; rdy0 = $urandom_range(0, 2) != 0;
      flush0 = $urandom_range(0, 15) == 0; in0 = mk($urandom());
      cycle();
      if (n == 300) begin
        #2 rst_i = 1'b1;
        #1;
        chk("rst_mid_valid", 128'(valid_d1), 128'(0));
        chk("rst_mid_pay", out1, BUBBLE);
        chk("rst_mid_ready", 128'(ready_f1), 128'(1));
        chk("rst_mid_valid0", 128'(valid_d0), 128'(0));
        q1.delete();
        q0.delete();
        @(posedge clk);
        #1 rst_i = 1'b0;
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
